weight2_update_module: RTL and testbench
========================================

WEIGHT2_UPDATE_MODULE -- requirements
Module: weight2_update_module

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the only clock, and rst is asynchronous and active-high.
REQ-002 The block SHALL have these ports:
  clk          input   1   sole clock, rising edge
  rst          input   1   asynchronous reset, active-high
  step         input   4   training step; 0 = warm-up, no updates
  controller   input   4   global phase code; 4'd10 = weight-commit phase
  load_en      input   1   preload strobe for one weight
  load_idx     input   3   preload weight index
  load_data    input   16  preload value, signed Q6.10
  upd_valid    input   1   delta-weight presented
  upd_idx      input   3   target weight index for delta
  deltaw2      input   16  signed Q6.10 delta weight (producer output)
  upd_ready    output  1   block accepts a delta this cycle
  rd_idx       input   3   read-back index
  rd_weight    output  16  signed Q6.10 weight, registered read
  upd_cnt      output  4   deltas accepted in current commit phase
  done         output  1   one-cycle pulse, commit phase complete
REQ-003 The block SHALL have one parameter: NW, default 8, the number of weights held.

Function
REQ-004 The block SHALL hold NW signed 16-bit Q6.10 weights in registers.
REQ-005 The FSM SHALL have three states: IDLE, UPD and DONE.
REQ-006 In IDLE, if controller==4'd10 and step!=4'd0, the FSM SHALL move to UPD on the next edge; otherwise it stays in IDLE.
REQ-007 With step==4'd0, the FSM SHALL never leave IDLE, regardless of controller.
REQ-008 upd_ready SHALL be 1 only in UPD and 0 in IDLE and DONE.
REQ-009 A delta SHALL be accepted on any edge where upd_valid and upd_ready are both 1.
REQ-010 An accepted delta SHALL set weight[upd_idx] <= sat16(weight[upd_idx] - deltaw2), computed at 17-bit width.
REQ-011 sat16 SHALL clamp results above 32767 to 16'h7FFF and results below -32768 to 16'h8000; no wrap-around.
REQ-012 Each acceptance SHALL increment upd_cnt, which is 0 on entry to UPD.
REQ-013 On the 8th acceptance (upd_cnt 7->8), the FSM SHALL move to DONE.
REQ-014 The FSM SHALL go DONE->IDLE unconditionally after one cycle; done is 1 only in DONE.
REQ-015 If controller leaves 4'd10 while in UPD, the FSM SHALL go to IDLE next edge and discard the partial count; done is not asserted.
REQ-016 Repeated deltas to the same index within one phase SHALL accumulate sequentially; each uses the value written by the prior edge.
REQ-017 load_en SHALL be honoured only in IDLE, writing weight[load_idx] <= load_data; it is ignored in UPD and DONE.
REQ-018 rd_weight SHALL be registered: rd_weight <= weight[rd_idx] (pre-write value) every edge.
REQ-019 A write to index i is visible on rd_weight two edges after the write edge when rd_idx==i.
REQ-020 upd_cnt SHALL hold its value in DONE and clear on entry to IDLE.

Reset
REQ-021 While rst=1, asynchronously: all weights = 0, rd_weight = 0, upd_cnt = 0, done = 0, upd_ready = 0, state = IDLE.
REQ-022 Reset asserted mid-UPD SHALL abort the phase; after release, an update requires a fresh IDLE->UPD entry.
REQ-023 Outputs SHALL be defined (no X) from the first edge after reset release.

Verification
REQ-024 Preload: in IDLE, load_en=1, load_idx=0, load_data=16'h0400, rd_idx=0 -> rd_weight=16'h0400 within two edges.
REQ-025 Basic update: weight0=16'h0400, step=1, controller=10, one delta with idx 0 and deltaw2=16'h0020 -> weight0=16'h03E0 and upd_cnt=1.
REQ-026 Saturation, both directions:
  - weight1=16'h8010, deltaw2=16'h0020 -> 16'h8000
  - weight2=16'h7FF0, deltaw2=16'hFFE0 -> 16'h7FFF
REQ-027 Gating: step=0, controller=10, upd_valid=1 for 5 cycles -> upd_ready stays 0 and all weights are unchanged; load_en during UPD -> target weight unchanged.
REQ-028 Completion: 8 back-to-back accepted deltas -> done=1 for exactly one cycle after the 8th, then state IDLE and upd_cnt=0.
REQ-029 Abort paths:
  - rst pulsed after 3 accepts -> all weights 0, upd_ready 0, no done pulse.
  - controller changed to 4 after 3 accepts -> IDLE, no done pulse, the 3 updates retained.

Source files
------------

// File: rtl/weight2_update_module.sv
// Holds NW signed Q6.10 weights. During the weight-commit phase each accepted
// delta is subtracted with saturation; eight accepts close the phase.
//
// state  | meaning
// IDLE   | preload allowed, waiting for commit phase with a non-zero step
// UPD    | accepting deltas, counting accepts toward eight
// DONE   | one-cycle completion pulse, then back to IDLE
module weight2_update_module #(
    parameter int NW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  step,
    input  logic [3:0]  controller,
    input  logic        load_en,
    input  logic [2:0]  load_idx,
    input  logic [15:0] load_data,
    input  logic        upd_valid,
    input  logic [2:0]  upd_idx,
    input  logic [15:0] deltaw2,
    output logic        upd_ready,
    input  logic [2:0]  rd_idx,
    output logic [15:0] rd_weight,
    output logic [3:0]  upd_cnt,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UPD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] weight [NW];
    logic        ctrl_commit;
    logic        accept;
    logic        upd_in_range;
    logic        load_in_range;
    logic        rd_in_range;
    logic [15:0] cur_w;
    logic [16:0] diff;
    logic [15:0] new_w;

    assign ctrl_commit   = (controller == 4'd10);
    assign upd_ready     = (state == S_UPD);
    assign done          = (state == S_DONE);
    assign accept        = upd_valid & upd_ready;
    assign upd_in_range  = (32'(upd_idx) < NW);
    assign load_in_range = (32'(load_idx) < NW);
    assign rd_in_range   = (32'(rd_idx) < NW);

    // Subtract at 17 bits so the overflow direction is visible in the top two bits.
    always_comb begin
        cur_w = '0;
        if (upd_in_range) cur_w = weight[upd_idx];
        diff = {cur_w[15], cur_w} - {deltaw2[15], deltaw2};
        case (diff[16:15])
            2'b01:   new_w = 16'h7FFF;
            2'b10:   new_w = 16'h8000;
            default: new_w = diff[15:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            upd_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    upd_cnt <= '0;
                    if (ctrl_commit && step != 4'd0) state <= S_UPD;
                end
                S_UPD: begin
                    if (!ctrl_commit) begin
                        state   <= S_IDLE;
                        upd_cnt <= '0;
                    end else if (accept) begin
                        upd_cnt <= upd_cnt + 4'd1;
                        if (upd_cnt == 4'd7) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    upd_cnt <= '0;
                end
                default: begin
                    state   <= S_IDLE;
                    upd_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) weight[i] <= '0;
        end else if (state == S_IDLE && load_en && load_in_range) begin
            weight[load_idx] <= load_data;
        end else if (accept && upd_in_range) begin
            weight[upd_idx] <= new_w;
        end
    end

    // Read port samples the array before this edge's write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_weight <= '0;
        else if (rd_in_range) rd_weight <= weight[rd_idx];
        else rd_weight <= '0;
    end

endmodule

// File: tb/tb_weight2_update_module.sv
// Directed sequence with randomized data, checked against an arithmetic
// model of the weight array (signed subtract, clamp to 16 bits).
module tb_weight2_update_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  step;
    logic [3:0]  controller;
    logic        load_en;
    logic [2:0]  load_idx;
    logic [15:0] load_data;
    logic        upd_valid;
    logic [2:0]  upd_idx;
    logic [15:0] deltaw2;
    logic        upd_ready;
    logic [2:0]  rd_idx;
    logic [15:0] rd_weight;
    logic [3:0]  upd_cnt;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [8];
    int exp_cnt;

    weight2_update_module #(.NW(8)) dut (
        .clk(clk), .rst(rst), .step(step), .controller(controller),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .deltaw2(deltaw2),
        .upd_ready(upd_ready), .rd_idx(rd_idx), .rd_weight(rd_weight),
        .upd_cnt(upd_cnt), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sub_sat(logic [15:0] w, logic [15:0] d);
        int r;
        r = int'($signed(w)) - int'($signed(d));
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    function automatic logic [15:0] pick_data();
        case ($urandom_range(0, 4))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [15:0] data);
        load_en   = 1'b1;
        load_idx  = 3'(idx);
        load_data = data;
        tick();
        load_en = 1'b0;
        model[idx] = data;
    endtask

    task automatic read_check(input int idx, input logic [15:0] exp, input string tag);
        rd_idx = 3'(idx);
        tick();
        chk(tag, rd_weight, exp);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) read_check(i, model[i], tag);
    endtask

    task automatic start_phase(input logic [3:0] s);
        step       = s;
        controller = 4'd10;
        tick();
        exp_cnt = 0;
        chk("enter_ready", 16'(upd_ready), 16'd1);
        chk("enter_cnt", 16'(upd_cnt), 16'd0);
    endtask

    task automatic do_delta(input int idx, input logic [15:0] d);
        upd_valid = 1'b1;
        upd_idx   = 3'(idx);
        deltaw2   = d;
        tick();
        upd_valid = 1'b0;
        model[idx] = sub_sat(model[idx], d);
        exp_cnt++;
        chk("delta_cnt", 16'(upd_cnt), 16'(exp_cnt));
        chk("delta_done", 16'(done), 16'(exp_cnt == 8));
        chk("delta_ready", 16'(upd_ready), 16'(exp_cnt < 8));
    endtask

    initial begin
        rst = 1'b1; step = '0; controller = '0; load_en = 1'b0; load_idx = '0;
        load_data = '0; upd_valid = 1'b0; upd_idx = '0; deltaw2 = '0; rd_idx = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 16'(upd_ready), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_cnt", 16'(upd_cnt), 16'd0);
        chk("rst_rd", rd_weight, 16'd0);
        rst = 1'b0;
        tick();

        // preload with read-back two edges later
        rd_idx = 3'd0;
        load(0, 16'h0400);
        tick();
        chk("preload_rd", rd_weight, 16'h0400);
        load(1, 16'h8010);
        load(2, 16'h7FF0);
        for (int i = 3; i < 8; i++) load(i, 16'($urandom));

        // step 0 keeps the block idle even in the commit phase
        step = 4'd0; controller = 4'd10; upd_valid = 1'b1;
        upd_idx = 3'd0; deltaw2 = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate_ready", 16'(upd_ready), 16'd0);
        end
        upd_valid = 1'b0;
        controller = 4'd0;
        check_all("gate_weights");

        // full phase with saturation and same-index accumulation
        start_phase(4'd1);
        load_en = 1'b1; load_idx = 3'd5; load_data = ~model[5];
        tick();
        load_en = 1'b0;
        chk("upd_load_cnt", 16'(upd_cnt), 16'd0);
        do_delta(0, 16'h0020);
        do_delta(1, 16'h0020);
        do_delta(2, 16'hFFE0);
        do_delta(3, pick_data());
        do_delta(3, pick_data());
        do_delta(3, pick_data());
        do_delta(6, pick_data());
        do_delta(7, pick_data());
        controller = 4'd0;
        tick();
        chk("post_done", 16'(done), 16'd0);
        chk("post_cnt", 16'(upd_cnt), 16'd0);
        chk("post_ready", 16'(upd_ready), 16'd0);
        read_check(0, 16'h03E0, "basic_w0");
        read_check(1, 16'h8000, "sat_neg");
        read_check(2, 16'h7FFF, "sat_pos");
        check_all("phase1_weights");

        // controller leaves the commit phase after three accepts
        start_phase(4'($urandom_range(1, 15)));
        for (int i = 0; i < 3; i++) do_delta($urandom_range(0, 7), pick_data());
        controller = 4'd4;
        tick();
        chk("ctl_abort_ready", 16'(upd_ready), 16'd0);
        chk("ctl_abort_done", 16'(done), 16'd0);
        chk("ctl_abort_cnt", 16'(upd_cnt), 16'd0);
        tick();
        chk("ctl_abort_done2", 16'(done), 16'd0);
        check_all("ctl_abort_weights");

        // reset mid-phase clears everything asynchronously
        start_phase(4'd3);
        for (int i = 0; i < 3; i++) do_delta($urandom_range(0, 7), pick_data());
        #2 rst = 1'b1;
        #1;
        chk("rst_abort_ready", 16'(upd_ready), 16'd0);
        chk("rst_abort_cnt", 16'(upd_cnt), 16'd0);
        chk("rst_abort_done", 16'(done), 16'd0);
        chk("rst_abort_rd", rd_weight, 16'd0);
        controller = 4'd0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_after_ready", 16'(upd_ready), 16'd0);
        chk("rst_after_done", 16'(done), 16'd0);
        check_all("rst_abort_weights");

        // randomized full phases
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) load(i, pick_data());
            start_phase(4'($urandom_range(1, 15)));
            for (int i = 0; i < 8; i++) do_delta($urandom_range(0, 7), pick_data());
            controller = 4'd0;
            tick();
            chk("rand_post_done", 16'(done), 16'd0);
            chk("rand_post_cnt", 16'(upd_cnt), 16'd0);
            check_all("rand_weights");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
